keyword_scanner: RTL and testbench

Streaming ASCII keyword detector with a runtime-programmable pattern of up to MAX_LEN characters. It sits on the byte stream feeding the alert logic and generalises the fixed four-letter detector. Overlapping occurrences are detected, and idle cycles between bytes are tolerated. The block provides a one-cycle match pulse, a sticky alert with clear, and a saturating hit counter.

---
 rtl/keyword_scanner_if.sv | 37 +++
 rtl/keyword_scanner.sv | 113 +++++++++++
 tb/tb_keyword_scanner.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/keyword_scanner_if.sv
// Byte-stream and configuration bundle for keyword_scanner.
// Master drives the stream and configuration; slave returns match/alert/count/fill.
interface keyword_scanner_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  // in_valid qualifies in_ascii for one cycle; there is no back-pressure,
  // and a byte presented together with a config write is dropped.
  logic             in_valid;
  logic [7:0]       in_ascii;
  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic [7:0]       cfg_char;
  logic             cfg_len_we;
  logic [LW-1:0]    cfg_len;
  logic             alert_clr;
  logic             cnt_clr;
  logic             match;
  logic             alert;
  logic [CNT_W-1:0] hit_count;
  logic [LW-1:0]    fill;

  modport master (
    output in_valid, in_ascii, cfg_we, cfg_idx, cfg_char, cfg_len_we, cfg_len,
           alert_clr, cnt_clr,
    input  match, alert, hit_count, fill
  );

  modport slave (
    input  in_valid, in_ascii, cfg_we, cfg_idx, cfg_char, cfg_len_we, cfg_len,
           alert_clr, cnt_clr,
    output match, alert, hit_count, fill
  );
endinterface

// File: rtl/keyword_scanner.sv
// Streaming keyword detector with a runtime-programmable pattern of up to MAX_LEN bytes.
// Optional macro CASE_FOLD_EN: fold a-z to A-Z before every comparison.
module keyword_scanner #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  keyword_scanner_if.slave   bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  logic [7:0]       pat_q [MAX_LEN];
  logic [7:0]       pat_d [MAX_LEN];
  logic [7:0]       win_q [MAX_LEN-1];
  logic [7:0]       win_d [MAX_LEN-1];
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic             alert_q, alert_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             idx_ok;
  logic             cfg_wr;
  logic             accept;
  logic             hit;
  logic [LW-1:0]    len_m1;
  logic [LW-1:0]    pi;
  logic [LW:0]      fill_p1;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef CASE_FOLD_EN
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
    return c;
  endfunction

  always_comb begin
    pat_d   = pat_q;
    win_d   = win_q;
    len_d   = len_q;
    fill_d  = fill_q;
    pi      = '0;
    idx_ok  = (int'(bus.cfg_idx) < MAX_LEN);
    cfg_wr  = (bus.cfg_we && idx_ok) || bus.cfg_len_we;
    accept  = bus.in_valid && !cfg_wr;
    len_m1  = len_q - LW'(1);
    fill_p1 = {1'b0, fill_q} + (LW+1)'(1);

    // The incoming byte closes the pattern; history supplies the len-1 bytes before it.
    hit = accept && (len_q != '0) && (fill_p1 >= {1'b0, len_q}) &&
          (fold(bus.in_ascii) == fold(pat_q[len_m1[IW-1:0]]));
    for (int k = 0; k < MAX_LEN - 1; k++) begin
      if (k + 1 < int'(len_q)) begin
        pi = len_q - LW'(k + 2);
        if (fold(win_q[k]) != fold(pat_q[pi[IW-1:0]])) hit = 1'b0;
      end
    end

    if (bus.cfg_we && idx_ok) pat_d[bus.cfg_idx] = bus.cfg_char;
    if (bus.cfg_len_we)
      len_d = (bus.cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.cfg_len;

    // Stale window contents after a flush are masked by the fill check.
    if (cfg_wr) begin
      fill_d = '0;
    end else if (accept) begin
      for (int k = MAX_LEN - 2; k > 0; k--) win_d[k] = win_q[k-1];
      win_d[0] = bus.in_ascii;
      if (fill_q != LW'(MAX_LEN)) fill_d = fill_q + LW'(1);
    end

    match_d = hit;
    alert_d = hit || (alert_q && !bus.alert_clr);
    if (hit) begin
      if (bus.cnt_clr)       cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      else                   cnt_d = cnt_q;
    end else begin
      cnt_d = bus.cnt_clr ? '0 : cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) pat_q[i] <= 8'h00;
      pat_q[0] <= 8'h42;
      pat_q[1] <= 8'h4F;
      pat_q[2] <= 8'h4D;
      pat_q[3] <= 8'h42;
      for (int i = 0; i < MAX_LEN - 1; i++) win_q[i] <= 8'h00;
      len_q   <= LW'(4);
      fill_q  <= '0;
      match_q <= 1'b0;
      alert_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      win_q   <= win_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      alert_q <= alert_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.match     = match_q;
  assign bus.alert     = alert_q;
  assign bus.hit_count = cnt_q;
  assign bus.fill      = fill_q;
endmodule

// File: tb/tb_keyword_scanner.sv
// Directed bench for keyword_scanner: a default DUT plus a CNT_W=2 DUT sharing the stimulus.
module tb_keyword_scanner;
  localparam int MAX_LEN = 8;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   match_cnt = 0;
  int   m0;

  always #5 clk = ~clk;

  keyword_scanner_if #(.MAX_LEN(MAX_LEN), .CNT_W(16)) bus  ();
  keyword_scanner_if #(.MAX_LEN(MAX_LEN), .CNT_W(2))  bus2 ();

  keyword_scanner #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  keyword_scanner #(.MAX_LEN(MAX_LEN), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always @(negedge clk) if (!rst && bus.match) match_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus applied identically to both DUTs; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic v, input logic [7:0] a, input logic we, input logic [IW-1:0] idx,
                     input logic [7:0] ch, input logic lwe, input logic [LW-1:0] len,
                     input logic aclr, input logic cclr);
    bus.in_valid = v;  bus.in_ascii = a;  bus.cfg_we = we;  bus.cfg_idx = idx;
    bus.cfg_char = ch; bus.cfg_len_we = lwe; bus.cfg_len = len;
    bus.alert_clr = aclr; bus.cnt_clr = cclr;
    bus2.in_valid = v;  bus2.in_ascii = a;  bus2.cfg_we = we;  bus2.cfg_idx = idx;
    bus2.cfg_char = ch; bus2.cfg_len_we = lwe; bus2.cfg_len = len;
    bus2.alert_clr = aclr; bus2.cnt_clr = cclr;
    @(posedge clk); #1;
    bus.in_valid = 0;  bus.cfg_we = 0;  bus.cfg_len_we = 0;  bus.alert_clr = 0;  bus.cnt_clr = 0;
    bus2.in_valid = 0; bus2.cfg_we = 0; bus2.cfg_len_we = 0; bus2.alert_clr = 0; bus2.cnt_clr = 0;
  endtask

  task automatic send(input logic [7:0] a);
    cyc(1'b1, a, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  cnt2_exp [5];
    int          gaps [7];
    string       s;
    cnt2_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    gaps     = '{0, 1, 3, 2, 0, 1, 2};

    bus.in_valid = 0;  bus.in_ascii = 0;  bus.cfg_we = 0;  bus.cfg_idx = 0;  bus.cfg_char = 0;
    bus.cfg_len_we = 0; bus.cfg_len = 0;  bus.alert_clr = 0; bus.cnt_clr = 0;
    bus2.in_valid = 0; bus2.in_ascii = 0; bus2.cfg_we = 0; bus2.cfg_idx = 0; bus2.cfg_char = 0;
    bus2.cfg_len_we = 0; bus2.cfg_len = 0; bus2.alert_clr = 0; bus2.cnt_clr = 0;
    #2;
    check("rst_async_match", {31'd0, bus.match}, 32'd0);
    do_reset();

    check("rst_match", {31'd0, bus.match}, 32'd0);
    check("rst_alert", {31'd0, bus.alert}, 32'd0);
    check("rst_hits",  {16'd0, bus.hit_count}, 32'd0);
    check("rst_fill",  {28'd0, bus.fill}, 32'd0);

    // "xBOMBy": single pulse right after the second B
    m0 = match_cnt;
    send_str("xBOM");
    check("xbomby_pre", {31'd0, bus.match}, 32'd0);
    send("B");
    check("xbomby_match", {31'd0, bus.match}, 32'd1);
    check("xbomby_alert", {31'd0, bus.alert}, 32'd1);
    check("xbomby_hits",  {16'd0, bus.hit_count}, 32'd1);
    send("y");
    check("xbomby_drop",  {31'd0, bus.match}, 32'd0);
    check("xbomby_pulses", match_cnt - m0, 32'd1);
    check("xbomby_fill",  {28'd0, bus.fill}, 32'd6);

    // "BOMBOMB" with idle gaps: two overlapping hits
    cyc(1'b0, 8'h00, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b1);
    check("cnt_clr", {16'd0, bus.hit_count}, 32'd0);
    m0 = match_cnt;
    s = "BOMBOMB";
    for (int i = 0; i < 7; i++) begin
      send(s[i]);
      idle(gaps[i]);
    end
    idle(1);
    check("overlap_pulses", match_cnt - m0, 32'd2);
    check("overlap_hits", {16'd0, bus.hit_count}, 32'd2);
    check("fill_sat", {28'd0, bus.fill}, 32'd8);
    cyc(1'b0, 8'h00, 1'b0, '0, 8'h00, 1'b0, '0, 1'b1, 1'b0);
    check("aclr_alert", {31'd0, bus.alert}, 32'd0);
    check("aclr_hits", {16'd0, bus.hit_count}, 32'd2);

    // len=3 pattern "ABA" against "ABABA": hits on bytes 3 and 5
    cyc(1'b0, 8'h00, 1'b1, 3'd0, "A", 1'b1, 4'd3, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 3'd1, "B", 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 3'd2, "A", 1'b0, '0, 1'b0, 1'b0);
    check("cfg_flush_fill", {28'd0, bus.fill}, 32'd0);
    s = "ABABA";
    for (int i = 0; i < 5; i++) begin
      send(s[i]);
      check($sformatf("aba_byte%0d", i), {31'd0, bus.match}, (i == 2 || i == 4) ? 32'd1 : 32'd0);
    end

    // Clamped length with a colliding byte: B dropped, len becomes MAX_LEN
    do_reset();
    cyc(1'b1, "B", 1'b0, '0, 8'h00, 1'b1, 4'(MAX_LEN + 3), 1'b0, 1'b0);
    check("clamp_drop_fill", {28'd0, bus.fill}, 32'd0);
    m0 = match_cnt;
    send_str("BOMB");
    for (int i = 0; i < 3; i++) send(8'h00);
    check("clamp_no_early", match_cnt - m0, 32'd0);
    send(8'h00);
    check("clamp_len8_match", {31'd0, bus.match}, 32'd1);

    // len=0 disables detection
    cyc(1'b0, 8'h00, 1'b0, '0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
    m0 = match_cnt;
    send_str("BOMBB");
    idle(1);
    check("len0_no_hit", match_cnt - m0, 32'd0);

    // Saturating 2-bit counter, then hit-vs-clear precedence on the wide DUT
    do_reset();
    for (int r = 0; r < 5; r++) begin
      send_str("BOMB");
      check($sformatf("sat_cnt_%0d", r), {30'd0, bus2.hit_count}, {30'd0, cnt2_exp[r]});
    end
    check("wide_cnt5", {16'd0, bus.hit_count}, 32'd5);
    send_str("OM");
    cyc(1'b1, "B", 1'b0, '0, 8'h00, 1'b0, '0, 1'b1, 1'b1);
    check("clr_hit_match", {31'd0, bus.match}, 32'd1);
    check("clr_hit_alert", {31'd0, bus.alert}, 32'd1);
    check("clr_hit_cnt",   {16'd0, bus.hit_count}, 32'd1);

    // Reset mid-stream loses partial progress
    send_str("BOM");
    do_reset();
    send("B");
    check("midrst_match", {31'd0, bus.match}, 32'd0);
    check("midrst_fill",  {28'd0, bus.fill}, 32'd1);
    m0 = match_cnt;
    send_str("bomb");
    idle(1);
`ifdef CASE_FOLD_EN
    check("fold_lower", match_cnt - m0, 32'd1);
`else
    check("fold_lower", match_cnt - m0, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
